// File: rtl/dma_pkg.sv
// Shared definitions for the DMAC external-port bridge: default widths,
// bridge FSM encoding and the posted-write entry layout.
package dma_pkg;

  localparam int DEF_ADR_SIZE  = 16;
  localparam int DEF_DATA_SIZE = 16;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DRAIN    = 3'd1,
    RD_WAIT  = 3'd2,
    RD_ISSUE = 3'd3,
    RD_DONE  = 3'd4
  } state_t;

  typedef struct packed {
    logic [DEF_ADR_SIZE-1:0]  addr;
    logic [DEF_DATA_SIZE-1:0] data;
  } wr_entry_t;

endpackage

// File: rtl/dma_post_fifo.sv
// Posted-write FIFO. Pointers carry one extra wrap bit so full and empty
// are distinguished without a separate occupancy counter.
module dma_post_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

  assign dout  = mem[rd_ptr[AW-1:0]];
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

endmodule

// File: rtl/dma_ext_bridge.sv
// Bridge between the DMAC SP port and external data memory: writes are posted
// through a FIFO, reads wait for all earlier writes and then go to memory.
module dma_ext_bridge
  import dma_pkg::*;
#(
  parameter int ADR_SIZE   = DEF_ADR_SIZE,
  parameter int DATA_SIZE  = DEF_DATA_SIZE,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sp_en,
  input  logic                 wr_rd_sp,
  input  logic [ADR_SIZE-1:0]  SPA,
  input  logic [DATA_SIZE-1:0] SPD_OUT,
  output logic [DATA_SIZE-1:0] SPD_IN,
  output logic                 stall_ext,
  output logic                 ext_en,
  output logic                 ext_wr,
  output logic [ADR_SIZE-1:0]  ext_addr,
  output logic [DATA_SIZE-1:0] ext_wdata,
  input  logic [DATA_SIZE-1:0] ext_rdata,
  input  logic                 ext_ready,
  output logic                 wr_pending,
  output logic [2:0]           dbg_state
);

  localparam int ENTRY_W = ADR_SIZE + DATA_SIZE;

  // Handshakes: a DMAC request transfers in a cycle with sp_en=1 and
  // stall_ext=0, otherwise the DMAC holds it unchanged. A memory access
  // transfers in a cycle with ext_en=1 and ext_ready=1; until then every
  // ext_* output is held.
  state_t             state;
  state_t             state_nx;
  logic               full;
  logic               empty;
  logic               fifo_push;
  logic               fifo_pop;
  logic               bypass;
  logic               load_read;
  logic [ENTRY_W-1:0] fifo_dout;
  logic               wr_req;
  logic               rd_req;
  logic               bus_free;
  logic               serve_wr;

  assign wr_req    = sp_en & wr_rd_sp;
  assign rd_req    = sp_en & ~wr_rd_sp;
  assign bus_free  = ~ext_en | ext_ready;
  assign serve_wr  = (state == IDLE) | (state == DRAIN) | (state == RD_WAIT);
  assign stall_ext = (wr_req & full) | (rd_req & (state != RD_DONE));
  assign wr_pending = ~empty | (ext_en & ext_wr);
  assign dbg_state = state;

  // An empty FIFO with a free bus lets a write go straight onto the bus,
  // which gives the one-cycle write latency.
  always_comb begin
    fifo_pop  = 1'b0;
    bypass    = 1'b0;
    load_read = 1'b0;
    if (serve_wr && bus_free) begin
      if (!empty)                          fifo_pop  = 1'b1;
      else if (rd_req)                     load_read = 1'b1;
      else if (wr_req && state != RD_WAIT) bypass    = 1'b1;
    end
    fifo_push = wr_req & ~full & ~bypass;
  end

  dma_post_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   ({SPA, SPD_OUT}),
    .dout  (fifo_dout),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE, DRAIN, RD_WAIT: begin
        if (load_read)               state_nx = RD_ISSUE;
        else if (rd_req)             state_nx = RD_WAIT;
        else if (!empty || fifo_push) state_nx = DRAIN;
        else                         state_nx = IDLE;
      end
      RD_ISSUE: if (ext_ready) state_nx = RD_DONE;
      RD_DONE:  state_nx = empty ? IDLE : DRAIN;
      default:  state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ext_en    <= 1'b0;
      ext_wr    <= 1'b0;
      ext_addr  <= '0;
      ext_wdata <= '0;
    end else if (fifo_pop) begin
      ext_en                <= 1'b1;
      ext_wr                <= 1'b1;
      {ext_addr, ext_wdata} <= fifo_dout;
    end else if (bypass) begin
      ext_en    <= 1'b1;
      ext_wr    <= 1'b1;
      ext_addr  <= SPA;
      ext_wdata <= SPD_OUT;
    end else if (load_read) begin
      ext_en   <= 1'b1;
      ext_wr   <= 1'b0;
      ext_addr <= SPA;
    end else if (ext_en && ext_ready) begin
      ext_en <= 1'b0;
      ext_wr <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  SPD_IN <= '0;
    else if (state == RD_ISSUE && ext_ready)   SPD_IN <= ext_rdata;
  end

endmodule

// File: tb/tb_dma_ext_bridge.sv
// Directed bench for dma_ext_bridge: reset, posted writes, FIFO full stall,
// read-after-write ordering, memory wait states and reset mid-read.
module tb_dma_ext_bridge;
  import dma_pkg::*;

  localparam int AW = DEF_ADR_SIZE;
  localparam int DW = DEF_DATA_SIZE;
  localparam int EW = $bits(wr_entry_t);

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          sp_en = 1'b0;
  logic          wr_rd_sp = 1'b0;
  logic [AW-1:0] SPA = '0;
  logic [DW-1:0] SPD_OUT = '0;
  logic [DW-1:0] SPD_IN;
  logic          stall_ext;
  logic          ext_en;
  logic          ext_wr;
  logic [AW-1:0] ext_addr;
  logic [DW-1:0] ext_wdata;
  logic [DW-1:0] ext_rdata = '0;
  logic          ext_ready = 1'b1;
  logic          wr_pending;
  logic [2:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [EW-1:0] exp_q[$];

  always #5 clk = ~clk;

  dma_ext_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .sp_en      (sp_en),
    .wr_rd_sp   (wr_rd_sp),
    .SPA        (SPA),
    .SPD_OUT    (SPD_OUT),
    .SPD_IN     (SPD_IN),
    .stall_ext  (stall_ext),
    .ext_en     (ext_en),
    .ext_wr     (ext_wr),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_rdata  (ext_rdata),
    .ext_ready  (ext_ready),
    .wr_pending (wr_pending),
    .dbg_state  (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    sp_en    = 1'b1;
    wr_rd_sp = 1'b1;
    SPA      = a;
    SPD_OUT  = d;
  endtask

  task automatic drive_rd(input logic [AW-1:0] a);
    sp_en    = 1'b1;
    wr_rd_sp = 1'b0;
    SPA      = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wr_entry_t e;
    int seen, first_c, last_c, stalls, issue;
    logic accepted;

    // reset
    #3;
    check("rst_async_en", 32'(ext_en), 0);
    tick(); tick(); #2;
    rst = 1'b1;
    tick(); #2;
    check("rst_ext_en", 32'(ext_en), 0);
    check("rst_ext_wr", 32'(ext_wr), 0);
    check("rst_ext_addr", 32'(ext_addr), 0);
    check("rst_ext_wdata", 32'(ext_wdata), 0);
    check("rst_spd_in", 32'(SPD_IN), 0);
    check("rst_wr_pending", 32'(wr_pending), 0);
    check("rst_stall", 32'(stall_ext), 0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));

    // single write, one-cycle latency
    tick(); drive_wr(16'h0010, 16'h1234); #2;
    check("wr1_stall", 32'(stall_ext), 0);
    tick(); sp_en = 1'b0; #2;
    check("wr1_en", 32'(ext_en), 1);
    check("wr1_wr", 32'(ext_wr), 1);
    check("wr1_addr", 32'(ext_addr), 'h10);
    check("wr1_data", 32'(ext_wdata), 'h1234);
    check("wr1_pending", 32'(wr_pending), 1);
    tick(); #2;
    check("wr1_done_en", 32'(ext_en), 0);
    check("wr1_done_pending", 32'(wr_pending), 0);

    // six writes against a stalled memory: five accepted, sixth stalls
    ext_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(); drive_wr(16'h0100 + 16'(i), 16'hA000 + 16'(i)); #2;
      check("burst_accept", 32'(stall_ext), 0);
      exp_q.push_back({SPA, SPD_OUT});
    end
    tick(); drive_wr(16'h0105, 16'hA005); #2;
    check("burst_full_stall", 32'(stall_ext), 1);
    check("burst_head_en", 32'(ext_en), 1);
    check("burst_head_addr", 32'(ext_addr), 'h100);
    ext_ready = 1'b1; #1;
    seen = 0; first_c = 0; last_c = 0;
    for (int c = 0; c < 20 && seen < 6; c++) begin
      accepted = sp_en && !stall_ext;
      if (accepted) exp_q.push_back({SPA, SPD_OUT});
      if (ext_en && ext_ready) begin
        if (exp_q.size() == 0) begin
          check("burst_extra", 32'(ext_addr), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("burst_addr", 32'(ext_addr), 32'(e.addr));
          check("burst_data", 32'(ext_wdata), 32'(e.data));
          check("burst_wr", 32'(ext_wr), 1);
        end
        if (seen == 0) first_c = c;
        last_c = c;
        seen++;
      end
      tick();
      if (accepted) sp_en = 1'b0;
      #2;
    end
    check("burst_count", seen, 6);
    check("burst_span", last_c - first_c, 5);
    check("burst_q_empty", exp_q.size(), 0);
    check("burst_idle_en", 32'(ext_en), 0);
    check("burst_idle_pending", 32'(wr_pending), 0);

    // write then read of the same address
    tick(); drive_wr(16'h0020, 16'hBEEF); #2;
    check("rw_wr_stall", 32'(stall_ext), 0);
    tick(); drive_rd(16'h0020); ext_rdata = 16'h0BAD; #2;
    check("rw_wr_on_bus", 32'(ext_wr), 1);
    check("rw_wr_addr", 32'(ext_addr), 'h20);
    stalls = 0;
    for (int c = 0; c < 10 && stall_ext; c++) begin
      stalls++;
      if (ext_en && !ext_wr) begin
        check("rw_rd_addr", 32'(ext_addr), 'h20);
        ext_rdata = 16'hBEEF;
      end
      tick(); #2;
    end
    check("rw_stall_cycles", stalls, 2);
    check("rw_stall_released", 32'(stall_ext), 0);
    check("rw_spd_in", 32'(SPD_IN), 'hBEEF);
    check("rw_state_done", 32'(dbg_state), 32'(RD_DONE));
    tick(); sp_en = 1'b0; ext_rdata = 16'h1111; #2;
    check("rw_back_idle", 32'(dbg_state), 32'(IDLE));
    check("rw_bus_idle", 32'(ext_en), 0);
    check("rw_spd_retained", 32'(SPD_IN), 'hBEEF);

    // read with three memory wait states
    tick(); drive_rd(16'h0055); ext_ready = 1'b0; ext_rdata = 16'hDEAD; #2;
    stalls = 0; issue = 0;
    for (int c = 0; c < 12 && stall_ext; c++) begin
      stalls++;
      if (ext_en) begin
        check("ws_addr_hold", 32'(ext_addr), 'h55);
        check("ws_rd", 32'(ext_wr), 0);
        check("ws_keep_spd", 32'(SPD_IN), 'hBEEF);
        issue++;
        if (issue == 4) begin
          ext_ready = 1'b1;
          ext_rdata = 16'h5A5A;
        end
      end
      tick(); #2;
    end
    check("ws_stall_cycles", stalls, 5);
    check("ws_stall_released", 32'(stall_ext), 0);
    check("ws_spd_in", 32'(SPD_IN), 'h5A5A);
    tick(); sp_en = 1'b0; #2;

    // reset asserted while a read is on the bus
    tick(); drive_rd(16'h0077); ext_ready = 1'b0; #2;
    tick(); #2;
    check("rsti_state", 32'(dbg_state), 32'(RD_ISSUE));
    check("rsti_en", 32'(ext_en), 1);
    sp_en = 1'b0;
    rst = 1'b0; #1;
    check("rsti_en_cleared", 32'(ext_en), 0);
    check("rsti_state_idle", 32'(dbg_state), 32'(IDLE));
    check("rsti_pending", 32'(wr_pending), 0);
    check("rsti_spd_in", 32'(SPD_IN), 0);
    check("rsti_stall", 32'(stall_ext), 0);
    rst = 1'b1;

    // reset abandons posted writes
    for (int i = 0; i < 3; i++) begin
      tick(); drive_wr(16'h0200 + 16'(i), 16'hC000 + 16'(i)); #2;
    end
    tick(); sp_en = 1'b0; #2;
    check("rstw_pending_before", 32'(wr_pending), 1);
    rst = 1'b0; #1;
    check("rstw_pending_cleared", 32'(wr_pending), 0);
    check("rstw_en_cleared", 32'(ext_en), 0);
    #1; rst = 1'b1; ext_ready = 1'b1;
    tick(); #2;
    check("rstw_no_issue_1", 32'(ext_en), 0);
    tick(); #2;
    check("rstw_no_issue_2", 32'(ext_en), 0);
    check("rstw_pending_after", 32'(wr_pending), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dma_ext_bridge.md
# dma_ext_bridge

External-port bridge between the DMAC SP (secondary/external) port and the external data memory. It posts DMAC writes into a small FIFO and drains them to a memory that may insert wait states. It serialises reads behind outstanding writes and drives the DMAC's `stall_ext` input so that the DMAC holds its request until the bridge can accept or complete it.

## Interface
Parameters:
- `ADR_SIZE`, 16, address width (SPA / ext_addr)
- `DATA_SIZE`, 16, data width
- `FIFO_DEPTH`, 4, posted-write entries (power of two, ≥2)

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - `clk`  in  1  single clock, rising edge
  - `rst`  in  1  asynchronous, active-low reset
- DMAC side:
  - `sp_en`  in  1  DMAC SP request valid
  - `wr_rd_sp`  in  1  1 = write, 0 = read
  - `SPA`  in  ADR_SIZE  request address
  - `SPD_OUT`  in  DATA_SIZE  write data from DMAC
  - `SPD_IN`  out  DATA_SIZE  read data to DMAC
  - `stall_ext`  out  1  DMAC must hold the current request
- Memory side:
  - `ext_en`  out  1  memory access valid
  - `ext_wr`  out  1  1 = write
  - `ext_addr`  out  ADR_SIZE  memory address
  - `ext_wdata`  out  DATA_SIZE  memory write data
  - `ext_rdata`  in  DATA_SIZE  memory read data, valid when `ext_ready` is 1
  - `ext_ready`  in  1  access completes this cycle (wait-state control)
- Status:
  - `wr_pending`  out  1  FIFO non-empty or a write is in flight on the memory bus

## Operation
- **Request acceptance.** A DMAC request is accepted in any cycle where `sp_en`=1 and `stall_ext`=0. While stalled, the DMAC holds `SPA`, `SPD_OUT` and `wr_rd_sp` stable.
- **Writes.**
  - `stall_ext` = `sp_en & wr_rd_sp & full`.
  - `full` is the registered state of the FIFO. A pop in the same cycle does not un-stall.
  - An accepted write pushes {SPA, SPD_OUT}.
- **Reads.**
  - `stall_ext` = `sp_en & ~wr_rd_sp & (state != RD_DONE)`.
- **FSM states:**
  - IDLE: default.
  - DRAIN: FIFO non-empty; issue the head entry. A new head is loaded onto the bus in the cycle the previous access completes (`ext_en & ext_ready`), giving back-to-back writes.
  - RD_WAIT: read pending; enter from IDLE/DRAIN on a read request. Stay until the FIFO is empty and the last write has completed. Then drive `ext_en`=1, `ext_wr`=0, `ext_addr`=SPA and go to RD_ISSUE.
  - RD_ISSUE: hold the bus until `ext_ready`=1. Capture `ext_rdata` into the `SPD_IN` register, drop `ext_en`, go to RD_DONE.
  - RD_DONE: `stall_ext`=0 for the read, so the DMAC consumes `SPD_IN` this cycle. Return to DRAIN if the FIFO is non-empty, else IDLE.
- **Bus hold rule.** Memory-bus outputs are registered. Once `ext_en`=1, `ext_addr`, `ext_wr` and `ext_wdata` are held until a cycle where `ext_ready`=1.
- **Ordering.** Writes pushed while a read is stalled are impossible, because the DMAC is held. A read therefore always observes every earlier write.
- **Simultaneous push and pop** when not full: both occur and the occupancy is unchanged.
- **Pointer wrap.** Pointers are `log2(FIFO_DEPTH)`+1 bits. Full is MSBs differ with LSBs equal; empty is pointers equal.
- **SPD_IN** retains its last read value between reads.

## Timing
- **Reset values:**
  - `ext_en`, `ext_wr`, `ext_addr`, `ext_wdata`, `SPD_IN`, `wr_pending` = 0.
  - FIFO pointers = 0; state = IDLE.
  - `stall_ext` is combinational; it is 0 whenever `sp_en`=0.
- **Write latency** (empty FIFO, `ext_ready`=1): accepted at cycle N, `ext_en`/`ext_wr`=1 with that entry at N+1. Throughput is 1 write/cycle.
- **Read latency** (empty FIFO, `ext_ready`=1): request at N with stall=1; RD_ISSUE at N+1; RD_DONE at N+2 with stall=0 and `SPD_IN` valid. Each memory wait state adds 1 cycle.
- **Reset mid-operation.** Reset abandons the FIFO contents and any access in flight. Outputs return to reset values asynchronously.

## Structure
- Package `dma_pkg`: default `ADR_SIZE`/`DATA_SIZE` constants, FSM state encoding (IDLE, DRAIN, RD_WAIT, RD_ISSUE, RD_DONE), write-entry struct {addr, data}.
- Sub-module `dma_post_fifo`: synchronous FIFO with `push`, `pop`, `din`, `dout`, `full` and `empty`, same clock and reset.
- FSM and bus registers live in the top level.

## Test plan
- Reset with `sp_en`=0, then release: all outputs 0, state IDLE, `stall_ext`=0.
- Write 0x1234 to 0x0010 with `ext_ready`=1: no stall, `ext_en`=`ext_wr`=1, `ext_addr`=0x0010, `ext_wdata`=0x1234 one cycle later.
- 6 back-to-back writes with `ext_ready`=0: first 5 accepted (4 in the FIFO plus 1 on the bus after the first issue), then `stall_ext`=1. Raise `ext_ready`: all 6 appear on the bus in order, 1/cycle.
- Write 0xBEEF to 0x0020, then read 0x0020 with memory returning 0xBEEF: the read stalls until the write completes; `SPD_IN`=0xBEEF in RD_DONE; total read stall 2 cycles after write drain.
- Read with `ext_ready` low for 3 cycles: `ext_addr` stable throughout, `stall_ext`=1 for 5 cycles, then data presented.
- Assert `rst` low during RD_ISSUE: `ext_en`=0 immediately, FIFO empty, `wr_pending`=0.
